// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word size, round constants, small-sigma functions and
// the message-schedule state encoding.
`timescale 1ns/1ps
package sha256_pkg;

  localparam int unsigned BlockSize = 512;
  localparam int unsigned WordSize  = 32;
  localparam int unsigned Rounds    = 64;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [WordSize-1:0] K [Rounds] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WordSize-1:0] sigma0(input logic [WordSize-1:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [WordSize-1:0] sigma1(input logic [WordSize-1:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_krom.sv
// Combinational round-constant lookup: 6-bit round index to 32-bit K_t.
`timescale 1ns/1ps
module sha256_krom
  import sha256_pkg::*;
(
  input  logic [5:0]          addr_i,
  output logic [WordSize-1:0] k_o
);

  assign k_o = K[addr_i];

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: loads one 512-bit block and streams W_t/K_t for t = 0..63.
// Define MSGSCHED_STALL_EN to honour wout_rdy; otherwise RUN advances every cycle.
`timescale 1ns/1ps
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BlockSize-1:0] blk_in,
  input  logic                 blkin_vld,
  output logic                 blkin_rdy,
  output logic [WordSize-1:0]  w_out,
  output logic [WordSize-1:0]  k_out,
  output logic [5:0]           round_idx,
  output logic                 wout_last,
  output logic                 wout_vld,
  input  logic                 wout_rdy
);

  state_e              state_q, state_d;
  logic [5:0]          t_q, t_d;
  logic [WordSize-1:0] sr_q [16];
  logic [WordSize-1:0] sr_d [16];
  logic [WordSize-1:0] w_new;
  logic [WordSize-1:0] k_rom;
  logic                rdy_eff;
  logic                running, last, xfer, load;

`ifdef MSGSCHED_STALL_EN
  assign rdy_eff = wout_rdy;
`else
  logic unused_wout_rdy;
  assign unused_wout_rdy = wout_rdy;
  assign rdy_eff         = 1'b1;
`endif

  assign running   = (state_q == StRun);
  assign last      = (t_q == 6'd63);
  assign xfer      = running & rdy_eff;
  // Ready on the final transfer lets the next block load without a bubble.
  assign blkin_rdy = ~running | (last & rdy_eff);
  assign load      = blkin_vld & blkin_rdy;

  assign w_new = sigma1(sr_q[14]) + sr_q[9] + sigma0(sr_q[1]) + sr_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    sr_d    = sr_q;
    if (xfer) begin
      for (int i = 0; i < 15; i++) begin
        sr_d[i] = sr_q[i+1];
      end
      sr_d[15] = w_new;
      t_d      = t_q + 6'd1;
      if (last) begin
        state_d = StIdle;
      end
    end
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        sr_d[i] = blk_in[BlockSize-1-WordSize*i -: WordSize];
      end
      t_d     = 6'd0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      t_q     <= 6'd0;
      sr_q    <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      sr_q    <= sr_d;
    end
  end

  sha256_krom u_krom (
    .addr_i (t_q),
    .k_o    (k_rom)
  );

  assign wout_vld  = running;
  assign w_out     = running ? sr_q[0] : '0;
  assign k_out     = running ? k_rom : '0;
  assign round_idx = running ? t_q : 6'd0;
  assign wout_last = running & last;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Scoreboard bench for sha256_msg_sched: a reference schedule is queued per accepted block
// and a negedge monitor checks handshakes and every presented word against it.
`timescale 1ns/1ps
module tb_sha256_msg_sched;

`ifdef MSGSCHED_STALL_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef struct {
    logic [31:0] w;
    logic [31:0] k;
    logic [5:0]  t;
    logic        last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [511:0] blk_in;
  logic         blkin_vld;
  logic         blkin_rdy;
  logic [31:0]  w_out, k_out;
  logic [5:0]   round_idx;
  logic         wout_last, wout_vld, wout_rdy;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          rdy_mode = 0;
  bit          rec_en = 1'b0;
  logic [31:0] obs_w [64];
  logic [31:0] obs_k [64];
  logic [511:0] abc_blk;

  always #5 clk = ~clk;

  sha256_msg_sched dut (
    .clk       (clk),
    .reset     (reset),
    .blk_in    (blk_in),
    .blkin_vld (blkin_vld),
    .blkin_rdy (blkin_rdy),
    .w_out     (w_out),
    .k_out     (k_out),
    .round_idx (round_idx),
    .wout_last (wout_last),
    .wout_vld  (wout_vld),
    .wout_rdy  (wout_rdy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference: the full 64-word schedule computed from the textbook recurrence.
  task automatic push_block(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    for (int t = 0; t < 64; t++) begin
      e.w = w[t];
      e.k = KT[t];
      e.t = 6'(t);
      e.last = (t == 63);
      q.push_back(e);
    end
  endtask

  // Monitor: expected ready/valid follow from how many words of the current block remain.
  always @(negedge clk) begin
    bit   eff, exp_vld, exp_rdy;
    exp_t e;
    if (!reset) q.delete();
    eff     = StallEn ? wout_rdy : 1'b1;
    exp_vld = (q.size() != 0);
    exp_rdy = (q.size() == 0) || (q.size() == 1 && eff);
    chk("wout_vld", 32'(wout_vld), 32'(exp_vld));
    chk("blkin_rdy", 32'(blkin_rdy), 32'(exp_rdy));
    if (exp_vld) begin
      e = q[0];
      chk("w_out", w_out, e.w);
      chk("k_out", k_out, e.k);
      chk("idx_last", {25'd0, wout_last, round_idx}, {25'd0, e.last, e.t});
      if (eff) begin
        if (rec_en) begin
          obs_w[e.t] = w_out;
          obs_k[e.t] = k_out;
        end
        void'(q.pop_front());
      end
    end else begin
      chk("idle_w", w_out, 32'd0);
      chk("idle_k", k_out, 32'd0);
      chk("idle_idx_last", {25'd0, wout_last, round_idx}, 32'd0);
    end
    if (reset && blkin_vld && exp_rdy) push_block(blk_in);
  end

  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin wout_rdy = (phase == 0); phase = (phase + 1) % 3; end
        2: wout_rdy = 1'($urandom_range(0, 1));
        3: wout_rdy = 1'b0;
        default: wout_rdy = 1'b1;
      endcase
    end
  end

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic load_block(input logic [511:0] b);
    bit got = 1'b0;
    blk_in    = b;
    blkin_vld = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (blkin_rdy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("load_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    blkin_vld = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) begin
      obs_w[i] = 32'hdeadbeef;
      obs_k[i] = 32'hdeadbeef;
    end
  endtask

  initial begin
    reset     = 1'b0;
    blkin_vld = 1'b0;
    blk_in    = '0;
    wout_rdy  = 1'b1;
    abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // "abc" block, directed values
    clear_obs();
    rec_en = 1'b1;
    load_block(abc_blk);
    drain();
    rec_en = 1'b0;
    chk("abc_w0", obs_w[0], 32'h61626380);
    chk("abc_w15", obs_w[15], 32'h00000018);
    chk("abc_w16", obs_w[16], 32'h61626380);
    chk("abc_w17", obs_w[17], 32'h000f0000);
    chk("abc_w18", obs_w[18], 32'h7da86405);
    chk("abc_k0", obs_k[0], 32'h428a2f98);
    chk("abc_k63", obs_k[63], 32'hc67178f2);

    // Back-to-back blocks
    load_block(rand_blk());
    load_block(rand_blk());
    drain();

    // Backpressure 1-on/2-off, then "abc" again for identical values
    rdy_mode = 1;
    clear_obs();
    rec_en = 1'b1;
    load_block(abc_blk);
    drain();
    rec_en = 1'b0;
    chk("stall_abc_w17", obs_w[17], 32'h000f0000);
    chk("stall_abc_w18", obs_w[18], 32'h7da86405);
    rdy_mode = 0;

`ifndef MSGSCHED_STALL_EN
    rdy_mode = 3;
    load_block(rand_blk());
    drain();
    rdy_mode = 0;
`endif

    // Reset in the middle of a block at t = 20
    load_block(rand_blk());
    repeat (20) @(posedge clk);
    #2;
    reset = 1'b0;
    q.delete();
    #1;
    chk("rst_vld", 32'(wout_vld), 32'd0);
    chk("rst_rdy", 32'(blkin_rdy), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    clear_obs();
    rec_en = 1'b1;
    load_block(abc_blk);
    drain();
    rec_en = 1'b0;
    chk("reload_w0", obs_w[0], 32'h61626380);

    // Early load attempt at t = 10 waits for t = 63
    load_block(rand_blk());
    repeat (10) @(posedge clk);
    #1;
    load_block(rand_blk());
    drain();

    // Random blocks with random backpressure and gaps
    rdy_mode = 2;
    for (int i = 0; i < 4; i++) begin
      load_block(rand_blk());
      repeat ($urandom_range(0, 70)) @(posedge clk);
      #1;
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
